mem_bus_ctrl: RTL and testbench

//  Memory controller directly downstream of the multicycle CPU core.

---
 rtl/mem_bus_if.sv | 44 ++++
 rtl/mem_bus_ctrl.sv | 112 +++++++++++
 tb/tb_mem_bus_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// Core-side request/ready channels and RAM-side strobes of the memory bus controller.
// master drives requests and RAM read data; slave is the controller.
interface mem_bus_if #(
    parameter int unsigned W = 32
);
    logic           if_req;
    logic [W-1:0]   if_addr;
    logic [W-1:0]   if_data;
    logic           if_ready;

    logic           ld_req;
    logic [W-1:0]   ld_addr;
    logic [W-1:0]   ld_data;
    logic           ld_ready;

    logic           st_req;
    logic [W-1:0]   st_addr;
    logic [W-1:0]   st_data;
    logic [W/8-1:0] st_be;
    logic           st_ready;

    logic           mem_en;
    logic           mem_we;
    logic [W/8-1:0] mem_be;
    logic [W-3:0]   mem_addr;
    logic [W-1:0]   mem_wdata;
    logic [W-1:0]   mem_rdata;

    logic           busy;

    modport master (
        output if_req, if_addr, ld_req, ld_addr,
               st_req, st_addr, st_data, st_be, mem_rdata,
        input  if_data, if_ready, ld_data, ld_ready, st_ready,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr,
               st_req, st_addr, st_data, st_be, mem_rdata,
        output if_data, if_ready, ld_data, ld_ready, st_ready,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Serializes fetch/load/store requests onto one single-port RAM with fixed read latency,
// returning completions as one-cycle ready pulses. Priority: store > load > fetch.
module mem_bus_ctrl #(
    parameter int unsigned W       = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic     clk,
    input  logic     rst,
    mem_bus_if.slave bus
);
    localparam int unsigned BE_W  = W / 8;
    localparam int unsigned AW    = W - 2;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACK  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rd_is_ld;

    // Byte-offset bits are irrelevant for word accesses.
    logic unused_ok;
    assign unused_ok = ^{bus.if_addr[1:0], bus.ld_addr[1:0], bus.st_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rd_is_ld      <= 1'b0;
            bus.if_data   <= '0;
            bus.if_ready  <= 1'b0;
            bus.ld_data   <= '0;
            bus.ld_ready  <= 1'b0;
            bus.st_ready  <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            // Strobes and ready pulses last exactly one cycle unless re-asserted below.
            bus.if_ready <= 1'b0;
            bus.ld_ready <= 1'b0;
            bus.st_ready <= 1'b0;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_be   <= '0;

            case (state)
                IDLE: begin
                    if (bus.st_req) begin
                        state         <= WR;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_be    <= BE_W'(bus.st_be);
                        bus.mem_addr  <= AW'(bus.st_addr[W-1:2]);
                        bus.mem_wdata <= bus.st_data;
                        bus.st_ready  <= 1'b1;
                        bus.busy      <= 1'b1;
                    end else if (bus.ld_req || bus.if_req) begin
                        state        <= RD;
                        rd_is_ld     <= bus.ld_req;
                        cnt          <= CNT_W'(MEM_LAT - 1);
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= bus.ld_req ? AW'(bus.ld_addr[W-1:2])
                                                   : AW'(bus.if_addr[W-1:2]);
                        bus.busy     <= 1'b1;
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end

                RD: begin
                    // Read data lands on the last RD cycle; capture it for the granted channel.
                    if (cnt == '0) begin
                        state <= ACK;
                        if (rd_is_ld) begin
                            bus.ld_data  <= bus.mem_rdata;
                            bus.ld_ready <= 1'b1;
                        end else begin
                            bus.if_data  <= bus.mem_rdata;
                            bus.if_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ACK: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                WR: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (MEM_LAT=2 and MEM_LAT=1), a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_mem_bus_ctrl;
    localparam int unsigned W = 32;
    localparam int LAT [2] = '{2, 1};

    typedef struct packed {
        logic        if_ready;
        logic        ld_ready;
        logic        st_ready;
        logic        mem_en;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [29:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] if_data;
        logic [31:0] ld_data;
        logic        busy;
    } obs_t;

    typedef struct packed {
        logic        if_req;
        logic        ld_req;
        logic        st_req;
        logic [31:0] if_addr;
        logic [31:0] ld_addr;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic [3:0]  st_be;
    } drv_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_if #(.W(W)) b0 ();
    mem_bus_if #(.W(W)) b1 ();

    mem_bus_ctrl #(.W(W), .MEM_LAT(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
    mem_bus_ctrl #(.W(W), .MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    drv_t drv [2];
    obs_t obs [2];

    assign b0.if_req  = drv[0].if_req;
    assign b0.ld_req  = drv[0].ld_req;
    assign b0.st_req  = drv[0].st_req;
    assign b0.if_addr = drv[0].if_addr;
    assign b0.ld_addr = drv[0].ld_addr;
    assign b0.st_addr = drv[0].st_addr;
    assign b0.st_data = drv[0].st_data;
    assign b0.st_be   = drv[0].st_be;
    assign b1.if_req  = drv[1].if_req;
    assign b1.ld_req  = drv[1].ld_req;
    assign b1.st_req  = drv[1].st_req;
    assign b1.if_addr = drv[1].if_addr;
    assign b1.ld_addr = drv[1].ld_addr;
    assign b1.st_addr = drv[1].st_addr;
    assign b1.st_data = drv[1].st_data;
    assign b1.st_be   = drv[1].st_be;

    assign obs[0] = {b0.if_ready, b0.ld_ready, b0.st_ready, b0.mem_en, b0.mem_we, b0.mem_be,
                     b0.mem_addr, b0.mem_wdata, b0.if_data, b0.ld_data, b0.busy};
    assign obs[1] = {b1.if_ready, b1.ld_ready, b1.st_ready, b1.mem_en, b1.mem_we, b1.mem_be,
                     b1.mem_addr, b1.mem_wdata, b1.if_data, b1.ld_data, b1.busy};

    // RAM environment: instance 0 has one pipeline register, instance 1 reads combinationally.
    logic [31:0] ram  [2][256];
    logic [31:0] pipe0;
    assign b0.mem_rdata = pipe0;
    assign b1.mem_rdata = ram[1][b1.mem_addr[7:0]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (obs[i].mem_en === 1'b1 && obs[i].mem_we === 1'b1)
                for (int b = 0; b < 4; b++)
                    if (obs[i].mem_be[b])
                        ram[i][obs[i].mem_addr[7:0]][8*b +: 8] <= obs[i].mem_wdata[8*b +: 8];
        end
        if (obs[0].mem_en === 1'b1 && obs[0].mem_we === 1'b0)
            pipe0 <= ram[0][obs[0].mem_addr[7:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s inst%0d: got %h, expected %h at %0t", nm, inst, act, want, $time);
        end
    endtask

    // Reference model: tracks cycles since grant per transaction, with its own memory image.
    logic [31:0] mram   [2][256];
    obs_t        expv   [2];
    bit          active [2];
    int          rem    [2];
    int          kind   [2];   // 0 fetch, 1 load, 2 store
    logic [31:0] maddr  [2];
    bit          chk_if [2];
    bit          chk_ld [2];
    bit          live = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            expv[i].if_ready = 1'b0;
            expv[i].ld_ready = 1'b0;
            expv[i].st_ready = 1'b0;
            expv[i].mem_en   = 1'b0;
            expv[i].mem_we   = 1'b0;
            expv[i].mem_be   = 4'h0;
            if (!rst) begin
                expv[i]   = '0;
                active[i] = 1'b0;
                chk_if[i] = 1'b1;
                chk_ld[i] = 1'b1;
                live      = 1'b1;
            end else if (!active[i]) begin
                expv[i].busy = 1'b0;
                if (drv[i].st_req) begin
                    active[i] = 1'b1;
                    rem[i]    = 0;
                    kind[i]   = 2;
                    expv[i].mem_en    = 1'b1;
                    expv[i].mem_we    = 1'b1;
                    expv[i].mem_be    = drv[i].st_be;
                    expv[i].mem_addr  = drv[i].st_addr[31:2];
                    expv[i].mem_wdata = drv[i].st_data;
                    expv[i].st_ready  = 1'b1;
                    expv[i].busy      = 1'b1;
                    for (int b = 0; b < 4; b++)
                        if (drv[i].st_be[b])
                            mram[i][drv[i].st_addr[9:2]][8*b +: 8] = drv[i].st_data[8*b +: 8];
                end else if (drv[i].ld_req || drv[i].if_req) begin
                    active[i] = 1'b1;
                    rem[i]    = LAT[i];
                    kind[i]   = drv[i].ld_req ? 1 : 0;
                    maddr[i]  = drv[i].ld_req ? drv[i].ld_addr : drv[i].if_addr;
                    expv[i].mem_en   = 1'b1;
                    expv[i].mem_addr = maddr[i][31:2];
                    expv[i].busy     = 1'b1;
                    if (kind[i] == 1) chk_ld[i] = 1'b0;
                    else              chk_if[i] = 1'b0;
                end
            end else if (rem[i] == 0) begin
                active[i]    = 1'b0;
                expv[i].busy = 1'b0;
            end else begin
                rem[i]--;
                if (rem[i] == 0) begin
                    if (kind[i] == 1) begin
                        expv[i].ld_ready = 1'b1;
                        expv[i].ld_data  = mram[i][maddr[i][9:2]];
                        chk_ld[i]        = 1'b1;
                    end else begin
                        expv[i].if_ready = 1'b1;
                        expv[i].if_data  = mram[i][maddr[i][9:2]];
                        chk_if[i]        = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                check("if_ready", i, 32'(obs[i].if_ready), 32'(expv[i].if_ready));
                check("ld_ready", i, 32'(obs[i].ld_ready), 32'(expv[i].ld_ready));
                check("st_ready", i, 32'(obs[i].st_ready), 32'(expv[i].st_ready));
                check("mem_en",   i, 32'(obs[i].mem_en),   32'(expv[i].mem_en));
                check("mem_we",   i, 32'(obs[i].mem_we),   32'(expv[i].mem_we));
                check("mem_be",   i, 32'(obs[i].mem_be),   32'(expv[i].mem_be));
                check("busy",     i, 32'(obs[i].busy),     32'(expv[i].busy));
                if (expv[i].mem_en)
                    check("mem_addr", i, 32'(obs[i].mem_addr), 32'(expv[i].mem_addr));
                if (expv[i].mem_we)
                    check("mem_wdata", i, obs[i].mem_wdata, expv[i].mem_wdata);
                if (chk_if[i]) check("if_data", i, obs[i].if_data, expv[i].if_data);
                if (chk_ld[i]) check("ld_data", i, obs[i].ld_data, expv[i].ld_data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for its ready; checks grant strobe, latency, data.
    task automatic do_req(input int i, input int k, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input int gnt_n, input logic [29:0] exp_maddr,
                          input int exp_lat, input logic [31:0] exp_data, input bit drop);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        case (k)
            0: begin drv[i].if_req = 1'b1; drv[i].if_addr = addr; end
            1: begin drv[i].ld_req = 1'b1; drv[i].ld_addr = addr; end
            default: begin
                drv[i].st_req = 1'b1; drv[i].st_addr = addr;
                drv[i].st_data = data; drv[i].st_be = be;
            end
        endcase
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == gnt_n) begin
                check("grant_mem_en", i, 32'(obs[i].mem_en), 32'd1);
                check("grant_mem_addr", i, 32'(obs[i].mem_addr), 32'(exp_maddr));
                if (drop) begin
                    #1;
                    drv[i].if_req = 1'b0;
                    drv[i].ld_req = 1'b0;
                end
            end
            case (k)
                0:       got = obs[i].if_ready;
                1:       got = obs[i].ld_ready;
                default: got = obs[i].st_ready;
            endcase
        end
        check("latency", i, 32'(n), 32'(exp_lat));
        if (k == 0) check("if_data_lit", i, obs[i].if_data, exp_data);
        if (k == 1) check("ld_data_lit", i, obs[i].ld_data, exp_data);
        #1;
        drv[i].if_req = 1'b0;
        drv[i].ld_req = 1'b0;
        drv[i].st_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st_n, ld_n, if_n, st_c, ld_c, if_c;
        drv[0] = '0;
        drv[1] = '0;
        pipe0  = '0;
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 256; w++) ram[i][w] = 32'hA500_0000 + 32'(w);
        ram[0][4]   = 32'h2408_0005;
        ram[0][128] = 32'h1122_3344;
        ram[1][0]   = 32'h0000_1000;
        ram[1][1]   = 32'hCAFE_0001;
        ram[1][2]   = 32'h1234_5678;
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 256; w++) mram[i][w] = ram[i][w];

        repeat (3) @(posedge clk);
        idle(1);
        rst = 1'b1;
        idle(2);
        check("rst_if_data", 0, obs[0].if_data, 32'h0);
        check("rst_busy", 0, 32'(obs[0].busy), 32'h0);

        // Fetch with MEM_LAT=2: strobe one cycle after request, ready three cycles after.
        do_req(0, 0, 32'h10, 32'h0, 4'h0, 1, 30'd4, 3, 32'h2408_0005, 1'b0);
        idle(1);

        // Full-word store then load back; the load request is dropped after grant.
        do_req(0, 2, 32'h100, 32'hDEAD_BEEF, 4'hF, 1, 30'd64, 1, 32'h0, 1'b0);
        idle(1);
        do_req(0, 1, 32'h100, 32'h0, 4'h0, 1, 30'd64, 3, 32'hDEAD_BEEF, 1'b1);
        idle(1);

        // Single-lane store merges into existing word.
        do_req(0, 2, 32'h202, 32'h0000_AB00, 4'b0010, 1, 30'd128, 1, 32'h0, 1'b0);
        idle(1);
        do_req(0, 1, 32'h200, 32'h0, 4'h0, 1, 30'd128, 3, 32'h1122_AB44, 1'b0);
        idle(1);

        // All three channels at once: st, ld, if in that order.
        st_n = 0; ld_n = 0; if_n = 0; st_c = 0; ld_c = 0; if_c = 0;
        drv[0].st_req = 1'b1; drv[0].st_addr = 32'h300;
        drv[0].st_data = 32'h55AA_55AA; drv[0].st_be = 4'hF;
        drv[0].ld_req = 1'b1; drv[0].ld_addr = 32'h100;
        drv[0].if_req = 1'b1; drv[0].if_addr = 32'h10;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (obs[0].st_ready) begin st_c++; st_n = n; end
            if (obs[0].ld_ready) begin
                ld_c++; ld_n = n;
                check("multi_ld_data", 0, obs[0].ld_data, 32'hDEAD_BEEF);
            end
            if (obs[0].if_ready) begin
                if_c++; if_n = n;
                check("multi_if_data", 0, obs[0].if_data, 32'h2408_0005);
            end
            #1;
            if (obs[0].st_ready) drv[0].st_req = 1'b0;
            if (obs[0].ld_ready) drv[0].ld_req = 1'b0;
            if (obs[0].if_ready) drv[0].if_req = 1'b0;
        end
        check("multi_st_cycle", 0, 32'(st_n), 32'd1);
        check("multi_ld_cycle", 0, 32'(ld_n), 32'd5);
        check("multi_if_cycle", 0, 32'(if_n), 32'd9);
        check("multi_st_count", 0, 32'(st_c), 32'd1);
        check("multi_ld_count", 0, 32'(ld_c), 32'd1);
        check("multi_if_count", 0, 32'(if_c), 32'd1);
        do_req(0, 1, 32'h300, 32'h0, 4'h0, 1, 30'd192, 3, 32'h55AA_55AA, 1'b0);
        idle(1);

        // Reset during a read drops it silently; the reissued fetch completes normally.
        drv[0].if_req = 1'b1;
        drv[0].if_addr = 32'h20;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_if_ready", 0, 32'(obs[0].if_ready), 32'h0);
        check("rst_mid_if_data", 0, obs[0].if_data, 32'h0);
        check("rst_mid_mem_en", 0, 32'(obs[0].mem_en), 32'h0);
        check("rst_mid_busy", 0, 32'(obs[0].busy), 32'h0);
        #1;
        rst = 1'b1;
        do_req(0, 0, 32'h20, 32'h0, 4'h0, 1, 30'd8, 3, 32'hA500_0008, 1'b0);
        idle(1);

        // MEM_LAT=1 back-to-back fetches: ready every 3 cycles.
        do_req(1, 0, 32'h0, 32'h0, 4'h0, 1, 30'd0, 2, 32'h0000_1000, 1'b0);
        do_req(1, 0, 32'h4, 32'h0, 4'h0, 2, 30'd1, 3, 32'hCAFE_0001, 1'b0);
        do_req(1, 0, 32'h8, 32'h0, 4'h0, 2, 30'd2, 3, 32'h1234_5678, 1'b0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
